// File: rtl/memory_v2_if.sv
// memory_v2 request/response bus.
// Master issues req/we/addr/wdata/be; slave answers rdata/rvalid.
interface memory_v2_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, rvalid
  );
endinterface

// File: rtl/memory_v2.sv
// memory_v2: RAM + seven-segment + synchronised input MMIO unit.
// Optional macro SEG_HEX_DECODE_EN: seg registers hold a hex nibble.
module memory_v2 #(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 32,
  parameter int                RAM_DEPTH    = 992,
  parameter int                NUM_SEG      = 8,
  parameter logic [ADDR_W-1:0] SEG_TOP      = 10'h3FF,
  parameter int                NUM_SW       = 16,
  parameter int                NUM_BTN      = 4,
  parameter logic [ADDR_W-1:0] SW_ADDR      = 10'h3EF,
  parameter logic [ADDR_W-1:0] BTN_EVT_ADDR = 10'h3EE,
  parameter int                NUM_PMOD     = 2,
  parameter logic [ADDR_W-1:0] PMOD_TOP     = 10'h3EA
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_v2_if.slave            bus,
  input  logic [NUM_SW-1:0]     switch_array,
  input  logic [NUM_BTN-1:0]    buttons,
  input  logic [NUM_PMOD-1:0]   pmod_in,
  output logic [NUM_SEG*7-1:0]  seg,
  input  logic                  err_clr,
  output logic [7:0]            memory_error_vector
);
  localparam int BW = DATA_W / 8;

  logic [DATA_W-1:0]   mem [RAM_DEPTH];
  logic [6:0]          seg_q [NUM_SEG];
`ifdef SEG_HEX_DECODE_EN
  logic [3:0]          nib_q [NUM_SEG];
`endif
  logic [NUM_SW-1:0]   sw_s1, sw_s2;
  logic [NUM_BTN-1:0]  btn_s1, btn_s2, btn_s3;
  logic [NUM_PMOD-1:0] pmod_s1, pmod_s2;
  logic [NUM_BTN-1:0]  evt_q;
  logic [3:0]          err_q, err_set;

  logic                wr, rd;
  logic [NUM_SEG-1:0]  hit_seg;
  logic [NUM_PMOD-1:0] hit_pmod;
  logic                hit_sw, hit_evt, hit_mmio;
  logic                hit_ram, hit_none;
  logic [DATA_W-1:0]   rd_word;

  assign wr = bus.req & bus.we;
  assign rd = bus.req & ~bus.we;

`ifdef SEG_HEX_DECODE_EN
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction
`endif

  // Address decode; MMIO hits mask the RAM range
  always_comb begin
    hit_seg  = '0;
    hit_pmod = '0;
    for (int i = 0; i < NUM_SEG; i++)
      hit_seg[i] = bus.addr == ADDR_W'(int'(SEG_TOP) - i);
    for (int j = 0; j < NUM_PMOD; j++)
      hit_pmod[j] = bus.addr == ADDR_W'(int'(PMOD_TOP) - j);
    hit_sw   = bus.addr == SW_ADDR;
    hit_evt  = bus.addr == BTN_EVT_ADDR;
    hit_mmio = (|hit_seg) | (|hit_pmod) | hit_sw | hit_evt;
    hit_ram  = !hit_mmio && (int'(bus.addr) < RAM_DEPTH);
    hit_none = !hit_mmio && !hit_ram;
  end

  // Read data mux for the addressed target
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      hit_ram: rd_word = mem[bus.addr];
      |hit_seg: begin
        for (int i = 0; i < NUM_SEG; i++)
          if (hit_seg[i])
`ifdef SEG_HEX_DECODE_EN
            rd_word = DATA_W'(nib_q[i]);
`else
            rd_word = DATA_W'(seg_q[i]);
`endif
      end
      hit_sw:  rd_word = DATA_W'({btn_s2, sw_s2});
      hit_evt: rd_word = DATA_W'(evt_q);
      |hit_pmod: begin
        for (int j = 0; j < NUM_PMOD; j++)
          if (hit_pmod[j]) rd_word = DATA_W'(pmod_s2[j]);
      end
      default: rd_word = '0;
    endcase
  end

  // Error causes for this cycle's access
  always_comb begin
    err_set    = '0;
    err_set[0] = wr & hit_none;
    err_set[1] = rd & hit_none;
    err_set[2] = wr & (hit_sw | hit_evt | (|hit_pmod));
    err_set[3] = wr & (|hit_seg) & ~bus.be[0];
  end

  // RAM byte-lane writes, suppressed while in reset
  always_ff @(posedge clk) begin
    if (rst && wr && hit_ram)
      for (int b = 0; b < BW; b++)
        if (bus.be[b]) mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
  end

  // Registered read response
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= rd;
      if (rd) bus.rdata <= rd_word;
    end
  end

  // Seven-segment registers, low byte lane only
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_q[i] <= 7'h7F;
`ifdef SEG_HEX_DECODE_EN
        nib_q[i] <= 4'h0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_SEG; i++)
        if (wr && hit_seg[i] && bus.be[0]) begin
`ifdef SEG_HEX_DECODE_EN
          nib_q[i] <= bus.wdata[3:0];
          seg_q[i] <= hex7(bus.wdata[3:0]);
`else
          seg_q[i] <= bus.wdata[6:0];
`endif
        end
    end
  end

  // Flatten segment registers onto the output bus
  always_comb begin
    seg = '0;
    for (int i = 0; i < NUM_SEG; i++) seg[7*i +: 7] = seg_q[i];
  end

  // Two-flop synchronisers plus button edge history
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_s3  <= '0;
      pmod_s1 <= '0;
      pmod_s2 <= '0;
    end else begin
      sw_s1   <= switch_array;
      sw_s2   <= sw_s1;
      btn_s1  <= buttons;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      pmod_s1 <= pmod_in;
      pmod_s2 <= pmod_s1;
    end
  end

  // Button events: read clears, a coincident edge wins
  always_ff @(posedge clk) begin
    if (!rst) evt_q <= '0;
    else evt_q <= ((rd && hit_evt) ? '0 : evt_q) | (btn_s2 & ~btn_s3);
  end

  // Sticky error flags: clear loses to a new error
  always_ff @(posedge clk) begin
    if (!rst) err_q <= '0;
    else err_q <= (err_clr ? 4'h0 : err_q) | err_set;
  end

  assign memory_error_vector = {4'h0, err_q};
endmodule

// File: tb/tb_memory_v2.sv
// Randomised scoreboard bench for memory_v2.
// Reads queue their expected word; a negedge monitor checks rvalid/rdata.
module tb_memory_v2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] switch_array = '0;
  logic [3:0]  buttons = '0;
  logic [1:0]  pmod_in = '0;
  logic [55:0] seg;
  logic        err_clr = 1'b0;
  logic [7:0]  memory_error_vector;

  always #5 clk = ~clk;

  memory_v2_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  memory_v2 dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .switch_array        (switch_array),
    .buttons             (buttons),
    .pmod_in             (pmod_in),
    .seg                 (seg),
    .err_clr             (err_clr),
    .memory_error_vector (memory_error_vector)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  // reference model state
  logic [31:0] ram_m [992];
  logic [6:0]  seg_m [8];
  logic [6:0]  segr_m [8];
  logic [7:0]  err_m = '0;
  logic [3:0]  evt_m = '0;
  logic [3:0]  btn_m = '0;
  logic [15:0] sw_m = '0;
  logic [1:0]  pmod_m = '0;
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};
  int ram_list [17];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // monitor: every rvalid must match the oldest queued read, one cycle late
  always @(negedge clk) begin
    if (bus.rvalid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL rvalid_spurious: rdata %h at cycle %0d",
                 bus.rdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.rdata !== e.data || cyc != e.cyc + 1) begin
          miscompares++;
          $display("FAIL read@%h: got %h cyc %0d, wanted %h cyc %0d",
                   e.addr, bus.rdata, cyc, e.data, e.cyc + 1);
        end
      end
    end
  end

  // 0 RAM, 1 SEG, 2 SW, 3 EVT, 4 PMOD, 5 unmapped
  function automatic void cls(input logic [9:0] a,
                              output int k, output int idx);
    idx = 0;
    if (a >= 10'h3F8) begin k = 1; idx = 10'h3FF - a; end
    else if (a == 10'h3EF) k = 2;
    else if (a == 10'h3EE) k = 3;
    else if (a == 10'h3EA || a == 10'h3E9) begin
      k = 4; idx = 10'h3EA - a;
    end
    else if (a < 10'd992) k = 0;
    else k = 5;
  endfunction

  function automatic logic [55:0] seg_pack();
    logic [55:0] s;
    for (int i = 0; i < 8; i++) s[7*i +: 7] = seg_m[i];
    return s;
  endfunction

  function automatic void seg_store(input int i, input logic [31:0] d);
`ifdef SEG_HEX_DECODE_EN
    seg_m[i]  = hex_tab[d[3:0]];
    segr_m[i] = {3'b0, d[3:0]};
`else
    seg_m[i]  = d[6:0];
    segr_m[i] = d[6:0];
`endif
  endfunction

  task automatic idle();
    bus.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // one bus access in one cycle; model updated in issue order
  task automatic op(input bit w, input logic [9:0] a,
                    input logic [31:0] d, input logic [3:0] b,
                    input bit clr);
    int k, idx;
    logic [7:0] set;
    logic [31:0] ex;
    bus.req = 1'b1; bus.we = w; bus.addr = a;
    bus.wdata = d; bus.be = b; err_clr = clr;
    cls(a, k, idx);
    set = '0;
    ex = '0;
    case (k)
      0: if (w) begin
           for (int i = 0; i < 4; i++)
             if (b[i]) ram_m[a][8*i +: 8] = d[8*i +: 8];
         end else ex = ram_m[a];
      1: if (w) begin
           if (b[0]) seg_store(idx, d);
           else set[3] = 1'b1;
         end else ex = {25'b0, segr_m[idx]};
      2: if (w) set[2] = 1'b1;
         else ex = {12'b0, btn_m, sw_m};
      3: if (w) set[2] = 1'b1;
         else begin ex = {28'b0, evt_m}; evt_m = '0; end
      4: if (w) set[2] = 1'b1;
         else ex = {31'b0, pmod_m[idx]};
      default: if (w) set[0] = 1'b1;
               else set[1] = 1'b1;
    endcase
    if (!w) q.push_back('{cyc: cyc, addr: a, data: ex});
    err_m = (clr ? 8'h00 : err_m) | set;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    err_clr = 1'b0;
    chk("err_vec", {56'b0, memory_error_vector}, {56'b0, err_m});
    chk("seg_out", {8'b0, seg}, {8'b0, seg_pack()});
  endtask

  task automatic set_inputs(input logic [15:0] s, input logic [3:0] bt,
                            input logic [1:0] p);
    switch_array = s; buttons = bt; pmod_in = p;
    evt_m |= bt & ~btn_m;
    btn_m = bt; sw_m = s; pmod_m = p;
    repeat (3) idle();
  endtask

  task automatic init_segs();
    for (int i = 0; i < 8; i++)
      op(1'b1, 10'(10'h3FF - i), $urandom, 4'h1, 1'b0);
  endtask

  initial begin
    logic [3:0] old_evt;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0;
    bus.wdata = '0; bus.be = '0;
    for (int i = 0; i < 8; i++) begin
      seg_m[i] = 7'h7F; segr_m[i] = 7'h7F;
    end
    for (int i = 0; i < 16; i++) ram_list[i] = i;
    ram_list[16] = 991;

    // reset held low for two cycles
    rst = 1'b0;
    repeat (2) idle();
    chk("rst_rvalid", {63'b0, bus.rvalid}, 64'h0);
    chk("rst_rdata", {32'b0, bus.rdata}, 64'h0);
    chk("rst_err", {56'b0, memory_error_vector}, 64'h0);
    chk("rst_seg", {8'b0, seg}, {8'b0, {8{7'h7F}}});
    rst = 1'b1;
    idle();

    for (int i = 0; i < 17; i++)
      op(1'b1, 10'(ram_list[i]), $urandom, 4'hF, 1'b0);

    // byte-enable merge, boundary word, back-to-back reads
    op(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    op(1'b1, 10'd5, 32'h00000011, 4'h1, 1'b0);
    op(1'b0, 10'd5, '0, 4'h0, 1'b0);
    chk("ram_be_model", {32'b0, ram_m[5]}, 64'hDEADBE11);
    op(1'b1, 10'd991, 32'hCAFEF00D, 4'hF, 1'b0);
    op(1'b0, 10'd991, '0, 4'h0, 1'b0);
    op(1'b0, 10'd0, '0, 4'h0, 1'b0);

    // seg write/readback
    op(1'b1, 10'h3FF, 32'h40, 4'h1, 1'b0);
    op(1'b1, 10'h3F8, 32'h79, 4'h1, 1'b0);
`ifdef SEG_HEX_DECODE_EN
    op(1'b1, 10'h3FF, 32'h3, 4'h1, 1'b0);
    chk("seg0_hex3", {57'b0, seg[6:0]}, 64'h30);
`else
    chk("seg0_raw", {57'b0, seg[6:0]}, 64'h40);
    chk("seg7_raw", {57'b0, seg[55:49]}, 64'h79);
`endif
    op(1'b0, 10'h3FF, '0, 4'h0, 1'b0);
    init_segs();

    // inputs through synchronisers
    set_inputs(16'hA5A5, 4'b0010, 2'b10);
    op(1'b0, 10'h3EF, '0, 4'h0, 1'b0);
    op(1'b0, 10'h3E9, '0, 4'h0, 1'b0);
    op(1'b0, 10'h3EA, '0, 4'h0, 1'b0);

    // button events, read-to-clear
    op(1'b0, 10'h3EE, '0, 4'h0, 1'b0);
    set_inputs(16'hA5A5, 4'b0011, 2'b10);
    set_inputs(16'hA5A5, 4'b0010, 2'b10);
    op(1'b0, 10'h3EE, '0, 4'h0, 1'b0);
    op(1'b0, 10'h3EE, '0, 4'h0, 1'b0);

    // edge lands on the same edge as the clearing read
    buttons = 4'b0110;
    old_evt = evt_m;
    repeat (2) idle();
    op(1'b0, 10'h3EE, '0, 4'h0, 1'b0);
    evt_m = old_evt | (4'b0110 & ~btn_m);
    btn_m = 4'b0110;
    idle();
    op(1'b0, 10'h3EE, '0, 4'h0, 1'b0);

    // error flags
    op(1'b1, 10'h3EF, 32'h1, 4'hF, 1'b0);
    chk("err_wr_ro", {56'b0, memory_error_vector}, 64'h04);
    op(1'b0, 10'h3F0, '0, 4'h0, 1'b0);
    chk("err_rd_unmap", {56'b0, memory_error_vector}, 64'h06);
    op(1'b1, 10'h3FF, 32'h12, 4'h2, 1'b0);
    chk("err_seg_be", {56'b0, memory_error_vector}, 64'h0E);
    err_clr = 1'b1;
    err_m = '0;
    idle();
    err_clr = 1'b0;
    chk("err_clr", {56'b0, memory_error_vector}, 64'h00);
    op(1'b1, 10'h3F1, 32'h0, 4'hF, 1'b1);
    chk("err_clr_vs_new", {56'b0, memory_error_vector}, 64'h01);

    // reset mid-operation: write dropped, read gets no rvalid
    set_inputs(16'h1234, 4'b0000, 2'b01);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 10'd5;
    bus.wdata = 32'h12345678; bus.be = 4'hF;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_drops_rvalid", {63'b0, bus.rvalid}, 64'h0);
    chk("rst_mid_err", {56'b0, memory_error_vector}, 64'h0);
    bus.req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seg_m[i] = 7'h7F; segr_m[i] = 7'h7F;
    end
    err_m = '0;
    evt_m = '0;
    chk("rst_mid_seg", {8'b0, seg}, {8'b0, seg_pack()});
    repeat (3) idle();
    op(1'b0, 10'd5, '0, 4'h0, 1'b0);
    op(1'b0, 10'h3EF, '0, 4'h0, 1'b0);
    init_segs();

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      int kind;
      logic [9:0] a;
      bit w, clr;
      kind = $urandom_range(0, 11);
      w = $urandom_range(0, 1) == 1;
      clr = $urandom_range(0, 7) == 0;
      case (kind)
        0, 1, 2, 3, 4: a = 10'(ram_list[$urandom_range(0, 16)]);
        5, 6: a = 10'(10'h3FF - $urandom_range(0, 7));
        7: a = 10'(10'h3E9 + $urandom_range(0, 6));
        8, 9: begin
          int k2, i2;
          do begin
            a = 10'($urandom_range(10'h3E0, 10'h3FF));
            cls(a, k2, i2);
          end while (k2 != 5);
        end
        10: a = 10'h3EE;
        default: a = 10'h3EF;
      endcase
      if (kind == 11 && w)
        set_inputs(16'($urandom), 4'($urandom), 2'($urandom));
      else
        op(w, a, $urandom, 4'($urandom), clr);
      if ($urandom_range(0, 9) == 0) idle();
    end

    repeat (3) idle();
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
